alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Initiator side of the ALU operand/result interface. It accepts ALU commands (op, rs, rt) over a valid/ready channel and buffers them in a small FIFO. It drives the combinational alu one command at a time from registered operands, then returns result, zero and a sequence tag over a valid/ready response channel. It sits between a command source (decode/test driver) and the alu.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
TAG_W, 4, width of the per-command sequence tag

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  FIFO can accept a command
cmd_op_i  input  op_code  operation
cmd_rs_i  input  32  operand A
cmd_rt_i  input  32  operand B
alu_op_o  output  op_code  registered op to alu
alu_rs_o  output  32  registered operand A to alu
alu_rt_o  output  32  registered operand B to alu
alu_result_i  input  32  alu result_o
alu_zero_i  input  1  alu zero
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  consumer accepts response
rsp_result_o  output  32  captured result
rsp_zero_o  output  1  captured zero flag
rsp_tag_o  output  TAG_W  tag of the originating command
count_o  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset low, async): FIFO empty, count_o=0, cmd_ready_o=1, tag counter=0, state IDLE. alu_op_o=ADD, alu_rs_o=alu_rt_o=0. rsp_valid_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_tag_o=0.
- Reset mid-operation: in-flight command and pending response are discarded, FIFO is flushed. After release, no response is produced for pre-reset commands.
- Accept: cmd_valid_i && cmd_ready_o at an edge pushes {op, rs, rt, tag}, and tag increments. The tag wraps from 2^TAG_W-1 to 0.
- cmd_ready_o = (count != DEPTH), decoded from registered count. It never depends on a same-cycle pop.
- Simultaneous push and pop: count unchanged, both take effect.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO non-empty, pop head into alu_* regs, go to ISSUE. Otherwise stay.
  - ISSUE: capture alu_result_i/alu_zero_i and the head's tag into rsp regs, set rsp_valid_o=1, go to RESP.
  - RESP: hold all rsp_* stable while rsp_ready_i=0. On rsp_ready_i=1, clear rsp_valid_o. If FIFO is non-empty that same edge, pop into alu_* regs and go to ISSUE; otherwise go to IDLE.
- Latency: command accepted at edge N with an idle, empty block -> popped at N+1 -> rsp_valid_o high after edge N+2.
- Throughput: one response per 2 cycles with rsp_ready_i held high.
- Responses are returned strictly in acceptance order.
- alu_* outputs hold their last value between commands; they do not return to reset values.
- Arithmetic is the alu's, 32-bit wrap-around. The issuer passes values through unchanged.

Optional Feature:
Macro ALU_OVF_FLAG_EN.
- Defined: adds output rsp_ovf_o (1 bit), captured in ISSUE together with the result.
  - ADD: 1 when alu_rs_o[31]==alu_rt_o[31] and alu_result_i[31] differs.
  - SUB: 1 when alu_rs_o[31]!=alu_rt_o[31] and alu_result_i[31]!=alu_rs_o[31].
  - Other ops: 0.
  - Reset value 0; held stable with the other rsp_* signals.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package definitions (existing, which holds op_code) gains:
  - typedef struct alu_cmd_t {op_code op; logic [31:0] rs, rt; logic [TAG_W-1:0] tag;}
  - enum issuer_state_t {IDLE, ISSUE, RESP}
  - localparam default TAG_W
- One sub-module, alu_cmd_fifo: a synchronous FIFO of alu_cmd_t with push/pop/full/empty/count and the same async active-low reset.
- The top instantiates the FIFO plus the FSM and response registers. The bench connects alu alongside it.

Test Plan:
- Single ADD rs=8 rt=4, rsp_ready_i=1 -> rsp_valid_o 2 cycles after accept; result=12, zero=0, tag=0.
- Back-to-back SUB 8,4 / OR FFFF0000,0000FFFF / AND FFFF0000,0000FFFF / SUB 10,10 -> in-order results 4, FFFFFFFF, 0 (zero=1), 0 (zero=1); tags 0,1,2,3; one response every 2 cycles.
- rsp_ready_i=0 while 5 commands are offered with DEPTH=4 -> count_o reaches 4, cmd_ready_o=0, rsp_* held stable. Release ready -> all commands complete in order with no loss or duplication.
- 17 commands -> tag sequence 0..15, 0 (wrap).
- Assert reset with a response pending and 2 commands queued -> immediately rsp_valid_o=0, count_o=0, cmd_ready_o=1; no stale responses afterwards.
- ALU_OVF_FLAG_EN: ADD 7FFFFFFF+1 -> result 80000000, ovf=1. SUB 80000000-1 -> ovf=1. SUB 4-8 -> FFFFFFFC, ovf=0.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer: opcode set, queued command record,
// issuer FSM states and the overflow rule used when ALU_OVF_FLAG_EN is defined.
package alu_cmd_issuer_pkg;

  localparam int DEFAULT_TAG_W = 4;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4,
    NOR  = 3'd5,
    SLT  = 3'd6,
    SLTU = 3'd7
  } op_code;

  typedef struct packed {
    op_code                   op;
    logic [31:0]              rs;
    logic [31:0]              rt;
    logic [DEFAULT_TAG_W-1:0] tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } issuer_state_t;

  // Signed overflow of the ALU result, judged from the operand and result sign bits.
  function automatic logic ovf_flag(input op_code op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] r);
    logic f;
    f = 1'b0;
    case (op)
      ADD:     f = (a[31] == b[31]) && (r[31] != a[31]);
      SUB:     f = (a[31] != b[31]) && (r[31] != a[31]);
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU issuer; DEPTH must be a power of two >= 2.
module alu_cmd_fifo
  import alu_cmd_issuer_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = alu_cmd_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator side of the ALU interface: queues commands, drives the alu from
// registered operands and returns tagged responses. Optional macro: ALU_OVF_FLAG_EN.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  op_code                   cmd_op_i,
  input  logic [31:0]              cmd_rs_i,
  input  logic [31:0]              cmd_rt_i,
  output op_code                   alu_op_o,
  output logic [31:0]              alu_rs_o,
  output logic [31:0]              alu_rt_o,
  input  logic [31:0]              alu_result_i,
  input  logic                     alu_zero_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_result_o,
  output logic                     rsp_zero_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
`ifdef ALU_OVF_FLAG_EN
  output logic                     rsp_ovf_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_RESP  = RESP;

  // Same layout as alu_cmd_t, but with this instance's tag width.
  typedef struct packed {
    op_code           op;
    logic [31:0]      rs;
    logic [31:0]      rt;
    logic [TAG_W-1:0] tag;
  } cmd_entry_t;

  logic [1:0]       state;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] issue_tag;
  cmd_entry_t       push_data;
  cmd_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign cmd_ready_o = !fifo_full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready_i));
  assign push_data   = '{op: cmd_op_i, rs: cmd_rs_i, rt: cmd_rt_i, tag: tag_cnt};

  alu_cmd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (cmd_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_o)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      alu_op_o     <= ADD;
      alu_rs_o     <= '0;
      alu_rt_o     <= '0;
      issue_tag    <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_tag_o    <= '0;
`ifdef ALU_OVF_FLAG_EN
      rsp_ovf_o    <= 1'b0;
`endif
    end else begin
      // alu_* only change on a pop, so they hold the last command between issues.
      if (pop) begin
        alu_op_o  <= head.op;
        alu_rs_o  <= head.rs;
        alu_rt_o  <= head.rt;
        issue_tag <= head.tag;
      end
      case (state)
        ST_IDLE: begin
          if (pop) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          rsp_valid_o  <= 1'b1;
          rsp_result_o <= alu_result_i;
          rsp_zero_o   <= alu_zero_i;
          rsp_tag_o    <= issue_tag;
`ifdef ALU_OVF_FLAG_EN
          rsp_ovf_o    <= ovf_flag(alu_op_o, alu_rs_o, alu_rt_o, alu_result_i);
`endif
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= pop ? ST_ISSUE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus randomized
// traffic scored against an in-order expected-response queue.
module tb_alu_cmd_issuer;
  import alu_cmd_issuer_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  op_code            cmd_op_i;
  logic [31:0]       cmd_rs_i;
  logic [31:0]       cmd_rt_i;
  op_code            alu_op_o;
  logic [31:0]       alu_rs_o;
  logic [31:0]       alu_rt_o;
  logic [31:0]       alu_result_i;
  logic              alu_zero_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_result_o;
  logic              rsp_zero_o;
  logic [TAG_W-1:0]  rsp_tag_o;
`ifdef ALU_OVF_FLAG_EN
  logic              rsp_ovf_o;
`endif
  logic [$clog2(DEPTH):0] count_o;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_rs_i     (cmd_rs_i),
    .cmd_rt_i     (cmd_rt_i),
    .alu_op_o     (alu_op_o),
    .alu_rs_o     (alu_rs_o),
    .alu_rt_o     (alu_rt_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .rsp_tag_o    (rsp_tag_o),
`ifdef ALU_OVF_FLAG_EN
    .rsp_ovf_o    (rsp_ovf_o),
`endif
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: both the stand-in for the real alu and the source of expected results.
  function automatic logic [31:0] alu_fn(input op_code op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOR:     return ~(a | b);
      SLT:     return {31'd0, $signed(a) < $signed(b)};
      default: return {31'd0, a < b};
    endcase
  endfunction

  function automatic logic ovf_ref(input op_code op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic [31:0] r;
    r = alu_fn(op, a, b);
    if (op == ADD) return (a[31] == b[31]) && (r[31] != a[31]);
    if (op == SUB) return (a[31] != b[31]) && (r[31] != a[31]);
    return 1'b0;
  endfunction

  always_comb begin
    alu_result_i = alu_fn(alu_op_o, alu_rs_o, alu_rt_o);
    alu_zero_i   = (alu_result_i == 32'd0);
  end

  typedef struct {
    logic [31:0]      res;
    logic             zero;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } exp_t;

  exp_t             exp_q[$];
  int               hs_cycles[$];
  logic [TAG_W-1:0] obs_tags[$];
  logic [TAG_W-1:0] tb_tag;
  bit               rand_ready = 0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: samples mid-low-phase; a handshake seen here completes on the next rising edge.
  initial begin : monitor
    bit               stalled;
    logic [31:0]      h_res;
    logic             h_zero;
    logic [TAG_W-1:0] h_tag;
    exp_t             e;
    stalled = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        exp_q.delete();
        stalled = 0;
      end else begin
        if (stalled) begin
          check("hold_valid", rsp_valid_o, 1'b1);
          check("hold_result", rsp_result_o, h_res);
          check("hold_zero", rsp_zero_o, h_zero);
          check("hold_tag", rsp_tag_o, h_tag);
        end
        if (rsp_valid_o && rsp_ready_i) begin
          hs_cycles.push_back(cyc);
          obs_tags.push_back(rsp_tag_o);
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_result", rsp_result_o, e.res);
            check("rsp_zero", rsp_zero_o, e.zero);
            check("rsp_tag", rsp_tag_o, e.tag);
`ifdef ALU_OVF_FLAG_EN
            check("rsp_ovf", rsp_ovf_o, e.ovf);
`endif
          end
        end
        stalled = rsp_valid_o && !rsp_ready_i;
        h_res   = rsp_result_o;
        h_zero  = rsp_zero_o;
        h_tag   = rsp_tag_o;
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(negedge clk);
      if (rand_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    check("global_timeout", 1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input op_code op, input logic [31:0] a, input logic [31:0] b);
    bit   done;
    bit   rdy;
    int   waited;
    exp_t e;
    done   = 0;
    waited = 0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_rs_i    = a;
    cmd_rt_i    = b;
    while (!done) begin
      rdy = cmd_ready_o;
      @(posedge clk);
      if (rdy) begin
        e.res  = alu_fn(op, a, b);
        e.zero = (e.res == 32'd0);
        e.tag  = tb_tag;
        e.ovf  = ovf_ref(op, a, b);
        exp_q.push_back(e);
        tb_tag = tb_tag + 1'b1;
        done   = 1;
      end
      @(negedge clk);
      waited++;
      if (!done && waited > 200) begin
        check("send_timeout", 1'b0, 1'b1);
        done = 1;
      end
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    tb_tag = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One isolated command checked against hand-derived constants.
  task automatic run_one(input string name, input op_code op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic zero,
                         input logic ovf);
    int n;
    send(op, a, b);
    n = 0;
    while (!rsp_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, rsp_valid_o, 1'b1);
    check({name, "_result"}, rsp_result_o, res);
    check({name, "_zero"}, rsp_zero_o, zero);
`ifdef ALU_OVF_FLAG_EN
    check({name, "_ovf"}, rsp_ovf_o, ovf);
`else
    if (ovf) n = 0;
`endif
    drain(20);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    cmd_valid_i = 1'b0;
    cmd_op_i    = ADD;
    cmd_rs_i    = '0;
    cmd_rt_i    = '0;
    rsp_ready_i = 1'b0;
    tb_tag      = '0;
    reset       = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_count", count_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_result", rsp_result_o, 0);
    check("rst_rsp_zero", rsp_zero_o, 1'b0);
    check("rst_rsp_tag", rsp_tag_o, 0);
    check("rst_alu_op", alu_op_o, ADD);
    check("rst_alu_rs", alu_rs_o, 0);
    check("rst_alu_rt", alu_rt_o, 0);
`ifdef ALU_OVF_FLAG_EN
    check("rst_rsp_ovf", rsp_ovf_o, 1'b0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // Single ADD: response visible after the second edge following acceptance.
    rsp_ready_i = 1'b1;
    send(ADD, 32'd8, 32'd4);
    check("lat_n0_valid", rsp_valid_o, 1'b0);
    @(negedge clk);
    check("lat_n1_valid", rsp_valid_o, 1'b0);
    @(negedge clk);
    check("lat_n2_valid", rsp_valid_o, 1'b1);
    check("add_result", rsp_result_o, 32'd12);
    check("add_zero", rsp_zero_o, 1'b0);
    check("add_tag", rsp_tag_o, 0);
    drain(20);

    // Back-to-back commands: in order, one response every two cycles.
    apply_reset();
    hs_cycles.delete();
    send(SUB, 32'd8, 32'd4);
    send(OR,  32'hFFFF_0000, 32'h0000_FFFF);
    send(AND, 32'hFFFF_0000, 32'h0000_FFFF);
    send(SUB, 32'd10, 32'd10);
    drain(100);
    check("b2b_count", hs_cycles.size(), 4);
    for (int i = 1; i < 4 && i < hs_cycles.size(); i++)
      check("b2b_gap", hs_cycles[i] - hs_cycles[i-1], 2);

    // Backpressure: 5 commands fill the FIFO behind one stalled response.
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(op_code'($urandom_range(0, 7)), $urandom, $urandom);
    check("full_count", count_o, DEPTH);
    check("full_ready", cmd_ready_o, 1'b0);
    check("full_rsp_valid", rsp_valid_o, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = XOR;
    cmd_rs_i    = 32'h1234_5678;
    cmd_rt_i    = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", cmd_ready_o, 1'b0);
      check("stall_count", count_o, DEPTH);
    end
    rsp_ready_i = 1'b1;
    send(XOR, 32'h1234_5678, 32'hFFFF_0000);
    drain(100);

    // Tag wrap over 17 commands.
    apply_reset();
    obs_tags.delete();
    for (int i = 0; i < 17; i++) send(ADD, i, 32'd1);
    drain(200);
    check("wrap_n", obs_tags.size(), 17);
    if (obs_tags.size() == 17) begin
      check("wrap_tag15", obs_tags[15], 15);
      check("wrap_tag16", obs_tags[16], 0);
    end

    // Reset with a response pending and two commands queued.
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(ADD, 32'd100, i);
    check("pre_rst_valid", rsp_valid_o, 1'b1);
    check("pre_rst_count", count_o, 2);
    #3;
    reset  = 1'b0;
    tb_tag = '0;
    #1;
    check("mid_rst_valid", rsp_valid_o, 1'b0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_ready", cmd_ready_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_valid", rsp_valid_o, 1'b0);
    check("post_rst_count", count_o, 0);

    // Sign-boundary cases (overflow flag checked when the feature is built in).
    run_one("ovf_add", ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    run_one("ovf_sub", SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_one("sub_neg", SUB, 32'd4, 32'd8, 32'hFFFF_FFFC, 1'b0, 1'b0);

    // Randomized traffic with random response backpressure.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      send(op_code'($urandom_range(0, 7)), pick_operand(), pick_operand());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_ready = 0;
    @(negedge clk);
    rsp_ready_i = 1'b1;
    drain(500);
    repeat (5) @(negedge clk);
    check("final_rsp_valid", rsp_valid_o, 1'b0);
    check("final_count", count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
